// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default frame constants shared by the UART blocks.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam int DBIT_DEFAULT    = 8;
  localparam int OVS_DEFAULT     = 16;
  localparam int SB_TICK_DEFAULT = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, resets to the idle-high level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) {s2_q, s1_q} <= 2'b11;
    else       {s2_q, s1_q} <= {s1_q, d_i};
  end
  assign q_o = s2_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver, samples each bit mid-period off s_tick.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT,
  parameter int OVS     = OVS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);
  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT);
  uart_rx_state_t  state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q, dout_q;
  logic            done_q, ferr_q, rx_s;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d_i(rx), .q_o(rx_s));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          s_q     <= '0;
        end
        START: if (s_tick) begin
          if (s_q == SW'(OVS/2-1)) begin
            // a start bit that is high again at its midpoint was a glitch
            state_q <= rx_s ? IDLE : DATA;
            s_q     <= '0;
            n_q     <= '0;
          end else s_q <= s_q + 1'b1;
        end
        DATA: if (s_tick) begin
          if (s_q == SW'(OVS-1)) begin
            b_q     <= {rx_s, b_q[DBIT-1:1]};
            s_q     <= '0;
            n_q     <= (n_q == NW'(DBIT-1)) ? n_q : n_q + 1'b1;
            state_q <= (n_q == NW'(DBIT-1)) ? STOP : DATA;
          end else s_q <= s_q + 1'b1;
        end
        STOP: if (s_tick) begin
          if (s_q == SW'(SB_TICK-1)) begin
            dout_q  <= b_q;
            ferr_q  <= ~rx_s;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else s_q <= s_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked every cycle against a tick-counting frame model.
module tb_uart_rx;
  localparam int DBIT = 8, OVS = 16, SB_TICK = 16;
  logic clk = 0, reset = 1, rx = 1, s_tick = 0;
  logic [DBIT-1:0] dout;
  logic rx_done_tick, frame_err;
  int tests = 0, fails = 0, ndone = 0, div = 1, tgen = 0;
  logic [7:0] got_q[$];
  uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .OVS(OVS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err));
  always #5 clk = ~clk;
  // model: a frame is a count of ticks since the start was seen; sample points fall at fixed tick offsets
  logic [1:0] msync = 2'b11;
  logic [7:0] mbits = '0, m_dout = '0;
  logic m_done = 0, m_ferr = 0, busy = 0, chk_en = 0;
  int tcnt = 0;
  always @(posedge clk) begin
    logic rxs;
    rxs = msync[1];
    if (reset) begin
      busy = 0; m_dout = '0; m_ferr = 0; m_done = 0; mbits = '0; msync = 2'b11; chk_en = 1;
    end else begin
      m_done = 0;
      if (!busy) begin
        if (!rxs) begin busy = 1; tcnt = 0; end
      end else if (s_tick) begin
        tcnt++;
        if (tcnt == OVS/2) begin
          if (rxs) busy = 0;
        end else if (tcnt <= OVS/2 + OVS*DBIT && (tcnt - OVS/2) % OVS == 0)
          mbits[(tcnt - OVS/2)/OVS - 1] = rxs;
        else if (tcnt == OVS/2 + OVS*DBIT + SB_TICK) begin
          m_dout = mbits; m_ferr = !rxs; m_done = 1; busy = 0;
        end
      end
      msync = {msync[0], rx};
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    tgen = (tgen + 1) % div;
    s_tick = (tgen == 0);
    if (chk_en) begin
      chk("cyc_dout", 32'(dout), 32'(m_dout));
      chk("cyc_done", 32'(rx_done_tick), 32'(m_done));
      chk("cyc_ferr", 32'(frame_err), 32'(m_ferr));
      if (rx_done_tick === 1'b1) begin ndone++; got_q.push_back(dout); end
    end
  end
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stopv, input int abort_bit);
    int bl = OVS * div;
    hold(1'b0, bl);
    for (int i = 0; i < DBIT; i++) begin
      if (i == abort_bit) begin
        hold(d[i], 4);
        reset = 1;
        @(negedge clk);
        reset = 0;
        rx = 1;
        return;
      end
      hold(d[i], bl);
    end
    hold(stopv, SB_TICK * div);
    rx = 1;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    int n0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rx = 1'($urandom);
      @(negedge clk);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_done", 32'(rx_done_tick), 0);
      chk("rst_ferr", 32'(frame_err), 0);
    end
    reset = 0;
    hold(1, 8);
    div = 4; n0 = ndone;
    send(8'hA5, 1, -1); hold(1, 8);
    chk("basic_cnt", ndone - n0, 1);
    chk("basic_dout", 32'(dout), 32'hA5);
    chk("basic_ferr", 32'(frame_err), 0);
    chk("model_pin_a5", 32'(m_dout), 32'hA5);
    div = 1; n0 = ndone;
    hold(0, 4); hold(1, 40);
    chk("glitch_cnt", ndone - n0, 0);
    chk("glitch_dout", 32'(dout), 32'hA5);
    n0 = ndone;
    send(8'h3C, 0, -1); hold(1, 40);
    chk("ferr_cnt", ndone - n0, 1);
    chk("ferr_dout", 32'(dout), 32'h3C);
    chk("ferr_flag", 32'(frame_err), 1);
    chk("model_pin_ferr", 32'(m_ferr), 1);
    send(8'h00, 1, -1); hold(1, 8);
    chk("ferr_clear_dout", 32'(dout), 32'h00);
    chk("ferr_clear_flag", 32'(frame_err), 0);
    n0 = ndone; got_q.delete();
    send(8'h01, 1, -1); send(8'hFF, 1, -1); send(8'h80, 1, -1); hold(1, 8);
    chk("b2b_cnt", ndone - n0, 3);
    chk("b2b_0", got_q.size() > 0 ? 32'(got_q[0]) : 32'hDEAD, 32'h01);
    chk("b2b_1", got_q.size() > 1 ? 32'(got_q[1]) : 32'hDEAD, 32'hFF);
    chk("b2b_2", got_q.size() > 2 ? 32'(got_q[2]) : 32'hDEAD, 32'h80);
    n0 = ndone;
    send(8'h55, 1, 3); hold(1, 200);
    chk("rstmid_cnt", ndone - n0, 0);
    chk("rstmid_dout", 32'(dout), 0);
    send(8'h96, 1, -1); hold(1, 8);
    chk("rstmid_next", 32'(dout), 32'h96);
    for (int f = 0; f < 40; f++) begin
      div = $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) begin
        hold(0, $urandom_range(1, 6)); hold(1, 12 * div);
      end
      send(8'($urandom), ($urandom_range(0, 7) != 0), -1);
      hold(1, $urandom_range(0, 30));
    end
    hold(1, 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Consumes the 16x-oversampling `tick` produced by `baud_generator` on input `s_tick`.
- Deserialises one 8N1 frame from the `rx` line and presents the byte on `dout`, with a one-clock `rx_done_tick` strobe.
- Sits between the board RX pin and the protocol logic. Runs in the 25 MHz system clock domain.

Parameters:
- DBIT, 8: number of data bits per frame, LSB first.
- SB_TICK, 16: number of `s_tick` pulses in the stop bit (16 = one stop bit).
- OVS, 16: number of `s_tick` pulses per bit period. Must be even.

Ports:
- clk  input  1  system clock, 25 MHz.
- reset  input  1  synchronous reset, active-high.
- rx  input  1  serial line, asynchronous, idles high.
- s_tick  input  1  oversampling enable from `baud_generator`; one-clock pulse, OVS per bit.
- dout  output  DBIT  last received byte.
- rx_done_tick  output  1  one-clock pulse when `dout` is updated.
- frame_err  output  1  stop-bit level of the last frame was 0; valid with and after `rx_done_tick`.

Behaviour:
- Interface is fixed:
  - one clock, `clk`;
  - `reset` is synchronous and active-high, sampled on rising `clk`.
- Reset values:
  - sync registers = 1;
  - state = IDLE; s = 0; n = 0; shift register b = 0;
  - dout = 0, rx_done_tick = 0, frame_err = 0.
- Input synchronizer:
  - two flops on `rx`; rx_s is the second flop;
  - all decisions use rx_s, so there are 2 cycles of input latency.
- Counters:
  - s: tick counter, width clog2(OVS), wraps to 0 explicitly;
  - n: bit counter, width clog2(DBIT).
  - Both change only on clocks with `s_tick` = 1, except the entry clear described under IDLE.
- IDLE:
  - if rx_s = 0, go to START with s = 0;
  - `s_tick` is not required for this transition.
- START:
  - on each tick, if s = OVS/2-1, check the mid-start sample:
    - rx_s = 0 -> go to DATA, s = 0, n = 0;
    - rx_s = 1 -> glitch; return to IDLE with no output.
  - Otherwise on a tick, s = s+1.
- DATA:
  - on a tick, if s = OVS-1:
    - b = {rx_s, b[DBIT-1:1]} (LSB first);
    - s = 0;
    - if n = DBIT-1, go to STOP, else n = n+1.
  - Otherwise on a tick, s = s+1.
  - Sampling therefore lands mid-bit.
- STOP:
  - on a tick, if s = SB_TICK-1:
    - registered outputs update on the next edge: dout = b, frame_err = ~rx_s, rx_done_tick = 1 for exactly one clock;
    - go to IDLE.
  - Otherwise on a tick, s = s+1.
- Outputs:
  - `dout` and `frame_err` hold until the next completed frame;
  - `rx_done_tick` is 0 at all other times.
- Framing error:
  - a frame with stop = 0 still delivers its byte and asserts `rx_done_tick`, with frame_err = 1;
  - the FSM returns to IDLE and re-arms on rx_s = 0. A line held low is treated as a new start bit.
- Reset during a frame: the next clock forces reset values and no `rx_done_tick` is emitted. The partial frame is lost.
- `s_tick` held high every clock is legal and is used to speed up simulation.
- Back-to-back frames: a start edge seen on the clock right after the STOP→IDLE transition must be accepted.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding `uart_rx_state_t` with values IDLE, START, DATA, STOP;
  - constants DBIT_DEFAULT = 8, OVS_DEFAULT = 16, SB_TICK_DEFAULT = 16;
  - these are shared with the future `uart_tx`.
- One sub-module, `sync_2ff`: the 1-bit two-flop synchronizer, reset value 1.
- The FSM and datapath stay in `uart_rx`.
- The top-level bench instantiates `baud_generator` + `uart_rx` together.

Test Plan:
- Basic byte: `baud_generator` drives `s_tick`; send 0xA5 as 8N1 (LSB first) at 16 ticks/bit -> one `rx_done_tick` pulse ~160 ticks after the start edge, dout = 0xA5, frame_err = 0.
- Glitch rejection: `s_tick` tied high; rx low for 4 clocks, then high -> FSM returns to IDLE, no `rx_done_tick`, dout keeps its previous value.
- Framing error: send 0x3C with stop bit = 0 -> `rx_done_tick` pulses, dout = 0x3C, frame_err = 1; then send 0x00 valid -> frame_err = 0.
- Back-to-back: send 0x01, 0xFF, 0x80 with no idle gap -> three pulses, dout sequence 0x01, 0xFF, 0x80.
- Reset mid-frame: start 0x55, assert reset for 1 clock during data bit 3 -> no pulse, dout = 0; next frame 0x96 -> dout = 0x96.
- Reset values: with reset high, check dout = 0, rx_done_tick = 0 and frame_err = 0 on every clock, with rx toggling.
